hpc3_rnd_gen: RTL and testbench

HPC3_RND_GEN -- requirements
Module: hpc3_rnd_gen

---
 rtl/hpc3_rnd_gen.sv | 145 ++++++++++++++
 tb/tb_hpc3_rnd_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hpc3_rnd_gen.sv
// Fresh-randomness source for HPC3 masked gadgets: NL parallel xorshift128 lanes,
// seeded word by word over a valid/ready port, one RND_W-bit draw per enabled cycle.
module hpc3_rnd_gen #(
   parameter  int security_order = 1,
   localparam int RND_W          = security_order * (security_order + 1),
   localparam int NL             = (RND_W + 31) / 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      seed_in,
   input  logic             seed_valid,
   output logic             seed_ready,
   input  logic             reseed,
   input  logic             en,
   output logic [RND_W-1:0] r,
   output logic             r_valid,
   output logic             seeded
);

   localparam int NWORDS = 4 * NL;
   localparam int CNT_W  = $clog2(NWORDS);
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

   // Word index inside a lane: 0 = x, 1 = y, 2 = z, 3 = w.
   typedef logic [3:0][31:0] lane_t;
   typedef enum logic {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_t;

   function automatic lane_t lane_step(input lane_t s);
      logic [31:0] t;
      lane_t       n;
      t    = s[0] ^ (s[0] << 5'd11);
      n[0] = s[1];
      n[1] = s[2];
      n[2] = s[3];
      n[3] = s[3] ^ (s[3] >> 5'd19) ^ t ^ (t >> 5'd8);
      return n;
   endfunction

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   lane_t [NL-1:0]     lane_q, lane_d;
   logic [RND_W-1:0]   r_q, r_d;
   logic               r_valid_q, r_valid_d;
   logic               seeded_q, seeded_d;
   logic               seed_ready_q, seed_ready_d;
   lane_t [NL-1:0]     stepped_s;
   logic [RND_W-1:0]   draw_s;
   logic               hs_s;

   assign hs_s       = seed_valid & seed_ready_q;
   assign seed_ready = seed_ready_q;
   assign seeded     = seeded_q;
   assign r          = r_q;
   assign r_valid    = r_valid_q;

   // Candidate next state of every lane for an enabled step.
   always_comb begin
      stepped_s = lane_q;
      for (int i = 0; i < NL; i++) begin
         stepped_s[i] = lane_step(lane_q[i]);
      end
   end

   // Draw = low RND_W bits of the concatenated new w words, lane 0 lowest.
   always_comb begin
      draw_s = '0;
      for (int b = 0; b < RND_W; b++) begin
         draw_s[b] = stepped_s[b / 32][3][b % 32];
      end
   end

   // Next-state logic: reseed beats everything, then load or run behaviour.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lane_d    = lane_q;
      r_d       = r_q;
      r_valid_d = 1'b0;
      if (reseed) begin
         state_d = ST_LOAD;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (hs_s) begin
                  for (int i = 0; i < NL; i++) begin
                     for (int j = 0; j < 4; j++) begin
                        lane_d[i][j] = (cnt_q == CNT_W'(4 * i + j)) ? seed_in : lane_q[i][j];
                     end
                  end
                  if (cnt_q == LAST_WORD) begin
                     state_d = ST_RUN;
                     cnt_d   = '0;
                     // An all-zero xorshift state is a fixed point; kick it out.
                     for (int i = 0; i < NL; i++) begin
                        lane_d[i][3] = (lane_d[i] == '0) ? 32'h0000_0001 : lane_d[i][3];
                     end
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
            ST_RUN: begin
               if (en) begin
                  lane_d    = stepped_s;
                  r_d       = draw_s;
                  r_valid_d = 1'b1;
               end else begin
                  r_valid_d = 1'b0;
               end
            end
            default: begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         endcase
      end
      seed_ready_d = (state_d == ST_LOAD);
      seeded_d     = (state_d == ST_RUN);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_LOAD;
         cnt_q        <= '0;
         lane_q       <= '0;
         r_q          <= '0;
         r_valid_q    <= 1'b0;
         seeded_q     <= 1'b0;
         seed_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lane_q       <= lane_d;
         r_q          <= r_d;
         r_valid_q    <= r_valid_d;
         seeded_q     <= seeded_d;
         seed_ready_q <= seed_ready_d;
      end
   end

endmodule

// File: tb/tb_hpc3_rnd_gen.sv
// Directed bench for hpc3_rnd_gen: single-cycle vector table on order 1, then
// reset/reseed sequences and a 1000-step model comparison on orders 1, 3 and 6.
module tb_hpc3_rnd_gen;

   localparam logic [31:0] S0 = 32'd123456789;
   localparam logic [31:0] S1 = 32'd362436069;
   localparam logic [31:0] S2 = 32'd521288629;
   localparam logic [31:0] S3 = 32'd88675123;
   localparam logic [31:0] W4 = 32'hDEAD_BEEF;
   localparam logic [31:0] W5 = 32'h0123_4567;
   localparam logic [31:0] W6 = 32'h89AB_CDEF;
   localparam logic [31:0] W7 = 32'h0F1E_2D3C;

   logic        clk = 1'b0;
   logic        rst_n, reseed, seed_valid, en;
   logic [31:0] seed_in;
   logic        rdy1, sd1, v1;
   logic [1:0]  r1;
   logic        rdy3, sd3, v3;
   logic [11:0] r3;
   logic        rdy6, sd6, v6;
   logic [41:0] r6;
   int          total  = 0;
   int          passed = 0;

   always #5 clk = ~clk;

   hpc3_rnd_gen #(.security_order(1)) u1 (
      .clk(clk), .rst_n(rst_n), .seed_in(seed_in), .seed_valid(seed_valid),
      .seed_ready(rdy1), .reseed(reseed), .en(en), .r(r1), .r_valid(v1), .seeded(sd1));
   hpc3_rnd_gen #(.security_order(3)) u3 (
      .clk(clk), .rst_n(rst_n), .seed_in(seed_in), .seed_valid(seed_valid),
      .seed_ready(rdy3), .reseed(reseed), .en(en), .r(r3), .r_valid(v3), .seeded(sd3));
   hpc3_rnd_gen #(.security_order(6)) u6 (
      .clk(clk), .rst_n(rst_n), .seed_in(seed_in), .seed_valid(seed_valid),
      .seed_ready(rdy6), .reseed(reseed), .en(en), .r(r6), .r_valid(v6), .seeded(sd6));

   typedef struct {
      string       name;
      logic        rst_n, reseed, seed_valid, en;
      logic [31:0] seed_in;
      logic        rdy, sdd, vld;
      logic [1:0]  r;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input string nm, input logic rn, input logic rs, input logic sv,
                               input logic e, input logic [31:0] si, input logic rdy,
                               input logic sdd, input logic vld, input logic [1:0] rr);
      vec_t v;
      v.name = nm; v.rst_n = rn; v.reseed = rs; v.seed_valid = sv; v.en = e; v.seed_in = si;
      v.rdy = rdy; v.sdd = sdd; v.vld = vld; v.r = rr;
      tbl.push_back(v);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic feed(input logic [31:0] wd);
      seed_valid = 1'b1;
      seed_in    = wd;
      tick();
      seed_valid = 1'b0;
   endtask

   // Reference xorshift128; state packed as {w, z, y, x}.
   function automatic logic [127:0] ref_step(input logic [127:0] s);
      logic [31:0] x, y, z, w, t;
      {w, z, y, x} = s;
      t = x ^ (x << 11);
      return {w ^ (w >> 19) ^ t ^ (t >> 8), w, z, y};
   endfunction

   initial begin
      logic [127:0] s0, s1;
      rst_n = 1'b0; reseed = 1'b0; seed_valid = 1'b0; en = 1'b0; seed_in = 32'd0;

      //   name           rst  rsd  sv   en   seed_in          rdy  sdd  vld  r
      add("reset",        0,   0,   0,   0,   32'd0,           1,   0,   0,   2'b00);
      add("reset_prio",   0,   0,   1,   1,   S0,              1,   0,   0,   2'b00);
      add("en_in_load",   1,   0,   0,   1,   32'd0,           1,   0,   0,   2'b00);
      add("word0",        1,   0,   1,   0,   S0,              1,   0,   0,   2'b00);
      add("word1",        1,   0,   1,   0,   S1,              1,   0,   0,   2'b00);
      add("bubble",       1,   0,   0,   0,   32'hFFFF_FFFF,   1,   0,   0,   2'b00);
      add("word2",        1,   0,   1,   0,   S2,              1,   0,   0,   2'b00);
      add("word3_run",    1,   0,   1,   0,   S3,              0,   1,   0,   2'b00);
      add("first_r",      1,   0,   0,   1,   32'd0,           0,   1,   1,   2'b10);
      add("hold_sv_ign",  1,   0,   1,   0,   32'h1234_5678,   0,   1,   0,   2'b10);
      add("reseed_prio",  1,   1,   1,   1,   32'hFFFF_FFFF,   1,   0,   0,   2'b10);
      add("zero_w0",      1,   0,   1,   0,   32'd0,           1,   0,   0,   2'b10);
      add("zero_w1",      1,   0,   1,   0,   32'd0,           1,   0,   0,   2'b10);
      add("zero_w2",      1,   0,   1,   0,   32'd0,           1,   0,   0,   2'b10);
      add("zero_w3",      1,   0,   1,   0,   32'd0,           0,   1,   0,   2'b10);
      add("zero_step1",   1,   0,   0,   1,   32'd0,           0,   1,   1,   2'b01);
      add("zero_step2",   1,   0,   0,   1,   32'd0,           0,   1,   1,   2'b01);
      add("zero_step3",   1,   0,   0,   1,   32'd0,           0,   1,   1,   2'b01);
      add("zero_step4",   1,   0,   0,   1,   32'd0,           0,   1,   1,   2'b00);
      add("zero_hold",    1,   0,   0,   0,   32'd0,           0,   1,   0,   2'b00);

      foreach (tbl[k]) begin
         rst_n = tbl[k].rst_n; reseed = tbl[k].reseed; seed_valid = tbl[k].seed_valid;
         en = tbl[k].en; seed_in = tbl[k].seed_in;
         tick();
         chk({tbl[k].name, ".seed_ready"}, 64'(rdy1), 64'(tbl[k].rdy));
         chk({tbl[k].name, ".seeded"},     64'(sd1),  64'(tbl[k].sdd));
         chk({tbl[k].name, ".r_valid"},    64'(v1),   64'(tbl[k].vld));
         chk({tbl[k].name, ".r"},          64'(r1),   64'(tbl[k].r));
      end
      rst_n = 1'b1; reseed = 1'b0; seed_valid = 1'b0; en = 1'b0;

      // Reset after two of four words must force a full reload.
      reseed = 1'b1; tick(); reseed = 1'b0;
      feed(S0); feed(S1); feed(S2); feed(S3);
      en = 1'b1; tick(); en = 1'b0;
      chk("reload_r", 64'(r1), 64'(2'b10));
      reseed = 1'b1; tick(); reseed = 1'b0;
      feed(S0); feed(S1);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk("midload_rst.r",          64'(r1),   64'd0);
      chk("midload_rst.r_valid",    64'(v1),   64'd0);
      chk("midload_rst.seeded",     64'(sd1),  64'd0);
      chk("midload_rst.seed_ready", 64'(rdy1), 64'd1);
      feed(S0); feed(S1); feed(S2);
      chk("after_rst_3words.seeded", 64'(sd1), 64'd0);
      feed(S3);
      chk("after_rst_4words.seeded", 64'(sd1), 64'd1);
      en = 1'b1; tick();
      chk("after_rst.r",       64'(r1), 64'(2'b10));
      chk("after_rst.r_valid", 64'(v1), 64'd1);
      rst_n = 1'b0; tick(); rst_n = 1'b1; en = 1'b0;
      chk("midrun_rst.r",          64'(r1),   64'd0);
      chk("midrun_rst.r_valid",    64'(v1),   64'd0);
      chk("midrun_rst.seed_ready", 64'(rdy1), 64'd1);

      // Shared 8-word load: orders 1 and 3 take the first four, order 6 all eight.
      feed(S0); feed(S1); feed(S2); feed(S3);
      chk("o1_seeded_4", 64'(sd1), 64'd1);
      chk("o3_seeded_4", 64'(sd3), 64'd1);
      chk("o6_seeded_4", 64'(sd6), 64'd0);
      feed(W4); feed(W5); feed(W6);
      chk("o6_seeded_7", 64'(sd6), 64'd0);
      feed(W7);
      chk("o6_seeded_8",    64'(sd6),  64'd1);
      chk("o6_ready_8",     64'(rdy6), 64'd0);
      s0 = {S3, S2, S1, S0};
      s1 = {W7, W6, W5, W4};
      en = 1'b1;
      for (int c = 0; c < 1000; c++) begin
         s0 = ref_step(s0);
         s1 = ref_step(s1);
         tick();
         if (c == 0) chk("first_w_o6", 64'(r6[31:0]), 64'h0000_0000_DCA3_45EA);
         chk("o1_r", 64'(r1), 64'(s0[97:96]));
         chk("o3_r", 64'(r3), 64'(s0[107:96]));
         chk("o6_r", 64'(r6), 64'({s1[105:96], s0[127:96]}));
         chk("o1_valid", 64'(v1 & v3 & v6), 64'd1);
      end
      en = 1'b0;
      tick();
      chk("stop.r_valid", 64'(v1 | v3 | v6), 64'd0);
      chk("stop.o1_hold", 64'(r1), 64'(s0[97:96]));
      chk("stop.o6_hold", 64'(r6), 64'({s1[105:96], s0[127:96]}));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
